gpio_pad_cfg_seq: RTL and testbench



---
 rtl/gpio_pad_cfg_seq.sv | 181 ++++++++++++++++++
 tb/tb_gpio_pad_cfg_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_cfg_seq.sv
// Pad-ring configuration sequencer: holds one config word per pad and shifts
// the whole set into the pad configuration chain, then pulses a load strobe.
module gpio_pad_cfg_seq #(
  parameter int                   NUM_PADS  = 8,
  parameter int                   CFG_WIDTH = 8,
  parameter logic [CFG_WIDTH-1:0] CFG_RESET = 8'h11,
  parameter int                   CLK_DIV   = 2,
  parameter int                   ADDR_W    = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [CFG_WIDTH-1:0] cfg_wdata,
  output logic [CFG_WIDTH-1:0] cfg_rdata,
  output logic                 cfg_err,
  input  logic                 apply_req,
  output logic                 apply_busy,
  output logic                 apply_done,
  output logic                 ser_clk,
  output logic                 ser_data,
  output logic                 ser_load
);

  localparam int TOTAL_BITS = NUM_PADS * CFG_WIDTH;
  localparam int CNT_W      = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    DONE
  } state_t;

  state_t                state;
  logic [CFG_WIDTH-1:0]  words [NUM_PADS];
  logic [TOTAL_BITS-1:0] words_flat;
  logic [TOTAL_BITS-1:0] next_flat;
  logic [TOTAL_BITS-1:0] snap;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic                  pending;
  logic                  addr_hit;
  logic                  wr_ok;
  logic                  div_end;

  always_comb begin
    addr_hit  = 1'b0;
    cfg_rdata = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      if (cfg_addr == ADDR_W'(i)) begin
        addr_hit  = 1'b1;
        cfg_rdata = words[i];
      end
    end
  end

  assign wr_ok   = cfg_we && (state == IDLE) && addr_hit;
  assign div_end = (div_cnt == DIV_LAST);

  // next_flat folds in a same-cycle write so a write+apply shifts the new value
  always_comb begin
    words_flat = '0;
    next_flat  = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      words_flat[i*CFG_WIDTH +: CFG_WIDTH] = words[i];
      next_flat[i*CFG_WIDTH +: CFG_WIDTH]  =
        (wr_ok && (cfg_addr == ADDR_W'(i))) ? cfg_wdata : words[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PADS; i++) words[i] <= CFG_RESET;
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_PADS; i++) begin
        if (cfg_addr == ADDR_W'(i)) words[i] <= cfg_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= cfg_we && !wr_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      snap       <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      pending    <= 1'b0;
      apply_busy <= 1'b0;
      apply_done <= 1'b0;
      ser_clk    <= 1'b0;
      ser_data   <= 1'b0;
      ser_load   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pending <= 1'b0;
          if (apply_req) begin
            state      <= SHIFT_LO;
            snap       <= next_flat;
            bit_cnt    <= LAST_BIT;
            div_cnt    <= '0;
            apply_busy <= 1'b1;
            ser_clk    <= 1'b0;
            ser_data   <= next_flat[LAST_BIT];
          end
        end
        SHIFT_LO: begin
          if (apply_req) pending <= 1'b1;
          if (div_end) begin
            state   <= SHIFT_HI;
            div_cnt <= '0;
            ser_clk <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (apply_req) pending <= 1'b1;
          if (div_end) begin
            div_cnt <= '0;
            ser_clk <= 1'b0;
            if (bit_cnt == '0) begin
              state    <= LOAD;
              ser_load <= 1'b1;
            end else begin
              state    <= SHIFT_LO;
              bit_cnt  <= bit_cnt - 1'b1;
              ser_data <= snap[bit_cnt - 1'b1];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        LOAD: begin
          if (apply_req) pending <= 1'b1;
          if (div_end) begin
            state      <= DONE;
            div_cnt    <= '0;
            ser_load   <= 1'b0;
            apply_done <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          apply_done <= 1'b0;
          pending    <= 1'b0;
          // A request arriving in this last busy cycle coalesces into the re-run
          if (pending || apply_req) begin
            state    <= SHIFT_LO;
            snap     <= words_flat;
            bit_cnt  <= LAST_BIT;
            div_cnt  <= '0;
            ser_data <= words_flat[LAST_BIT];
          end else begin
            state      <= IDLE;
            apply_busy <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          apply_busy <= 1'b0;
          apply_done <= 1'b0;
          ser_clk    <= 1'b0;
          ser_load   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_pad_cfg_seq.sv
// Scoreboard bench for gpio_pad_cfg_seq: expected chain frames and error
// pulses are queued by the stimulus and retired by an independent monitor.
module tb_gpio_pad_cfg_seq;

  localparam int NP      = 8;
  localparam int W       = 8;
  localparam int DIV     = 2;
  localparam int AW      = 4;
  localparam int TB      = NP * W;
  localparam int RUN_CYC = NP * W * 2 * DIV + DIV + 1;
  localparam logic [W-1:0] RST_VAL = 8'h11;

  logic          clk;
  logic          rst_n;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [W-1:0]  cfg_wdata;
  logic [W-1:0]  cfg_rdata;
  logic          cfg_err;
  logic          apply_req;
  logic          apply_busy;
  logic          apply_done;
  logic          ser_clk;
  logic          ser_data;
  logic          ser_load;

  gpio_pad_cfg_seq #(
    .NUM_PADS (NP),
    .CFG_WIDTH(W),
    .CFG_RESET(RST_VAL),
    .CLK_DIV  (DIV),
    .ADDR_W   (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .cfg_err   (cfg_err),
    .apply_req (apply_req),
    .apply_busy(apply_busy),
    .apply_done(apply_done),
    .ser_clk   (ser_clk),
    .ser_data  (ser_data),
    .ser_load  (ser_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TB-1:0] frame;
    int            cyc;
  } exp_t;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  int            rises = 0;
  int            rise_base = 0;
  int            loads = 0;
  logic [TB-1:0] shreg = '0;
  logic [W-1:0]  model [NP];
  exp_t          frame_q[$];
  int            err_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [TB-1:0] model_frame();
    logic [TB-1:0] f;
    for (int i = 0; i < NP; i++) f[i*W +: W] = model[i];
    return f;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Chain receiver: what the pads would have captured, MSB of pad NP-1 first
  always @(posedge ser_clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      rises <= 0;
    end else begin
      shreg <= {shreg[TB-2:0], ser_data};
      rises <= rises + 1;
    end
  end

  // Monitor: retires expected frames on apply_done and expected error pulses
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rise_base = 0;
        loads     = 0;
      end else begin
        if (ser_load) loads++;
        if (cfg_err) begin
          if (err_q.size() == 0) check("cfg_err_unexpected", 64'(cfg_err), 64'd0);
          else check("cfg_err_cycle", 64'(cyc), 64'(err_q.pop_front()));
        end
        if (apply_done) begin
          done_cnt++;
          if (frame_q.size() == 0) begin
            check("apply_done_unexpected", 64'(apply_done), 64'd0);
          end else begin
            e = frame_q.pop_front();
            check("frame", 64'(shreg), 64'(e.frame));
            check("done_cycle", 64'(cyc), 64'(e.cyc));
            check("ser_clk_rises", 64'(rises - rise_base), 64'(TB));
            check("load_len", 64'(loads), 64'(DIV));
          end
          rise_base = rises;
          loads     = 0;
        end
      end
    end
  end

  task automatic applyStimulus_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    if (int'(a) < NP) model[int'(a)] = d;
    else err_q.push_back(cyc + 1);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic checkOutput_read(input logic [AW-1:0] a);
    logic [W-1:0] exp;
    @(negedge clk);
    cfg_addr = a;
    #1;
    exp = (int'(a) < NP) ? model[int'(a)] : '0;
    check("cfg_rdata", 64'(cfg_rdata), 64'(exp));
  endtask

  // One apply, optionally with a same-cycle write, extra mid-run requests
  // (which trigger exactly one re-run) and a rejected write while busy
  task automatic applyStimulus_run(input int n_extra, input bit busy_wr, input bit wr,
                                   input logic [AW-1:0] a, input logic [W-1:0] d);
    int c;
    int n;
    int busy_cyc;
    int runs;
    exp_t e;
    @(negedge clk);
    if (wr) begin
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      if (int'(a) < NP) model[int'(a)] = d;
      else err_q.push_back(cyc + 1);
    end
    apply_req = 1'b1;
    c    = cyc;
    runs = (n_extra > 0) ? 2 : 1;
    for (int r = 0; r < runs; r++) begin
      e.frame = model_frame();
      e.cyc   = c + RUN_CYC * (r + 1);
      frame_q.push_back(e);
    end
    @(negedge clk);
    cfg_we    = 1'b0;
    apply_req = 1'b0;
    busy_cyc  = 0;
    n         = 1;
    while (apply_busy && n < 3000) begin
      busy_cyc++;
      apply_req = (n_extra > 0 && n % 50 == 0 && n / 50 <= n_extra);
      if (busy_wr && n == 30) begin
        cfg_we    = 1'b1;
        cfg_addr  = 4'd5;
        cfg_wdata = 8'hFF;
        err_q.push_back(cyc + 1);
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    apply_req = 1'b0;
    cfg_we    = 1'b0;
    check("busy_len", 64'(busy_cyc), 64'(RUN_CYC * runs));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    int dc;
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    apply_req = 1'b0;
    for (int i = 0; i < NP; i++) model[i] = RST_VAL;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({ser_clk, ser_data, ser_load, apply_busy, apply_done, cfg_err}), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < NP; i++) checkOutput_read(AW'(i));

    applyStimulus_write(4'd3, 8'h6A);
    checkOutput_read(4'd3);
    applyStimulus_run(0, 1'b0, 1'b0, '0, '0);

    applyStimulus_run(0, 1'b1, 1'b0, '0, '0);
    checkOutput_read(4'd5);

    applyStimulus_write(4'd9, 8'hC3);
    checkOutput_read(4'd9);

    dc = done_cnt;
    applyStimulus_run(3, 1'b0, 1'b0, '0, '0);
    check("rerun_done_pulses", 64'(done_cnt - dc), 64'd2);

    for (int it = 0; it < 4; it++) begin
      int nw;
      nw = int'($urandom_range(1, 4));
      for (int j = 0; j < nw; j++)
        applyStimulus_write(AW'($urandom_range(0, 9)), W'($urandom));
      for (int j = 0; j < 3; j++) checkOutput_read(AW'($urandom_range(0, 15)));
      applyStimulus_run(0, 1'b0, 1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, 7)), W'($urandom));
    end

    // Reset in the middle of a shift: nothing completes, words fall back
    dc = done_cnt;
    @(negedge clk);
    apply_req = 1'b1;
    @(negedge clk);
    apply_req = 1'b0;
    k = 0;
    while ((rises - rise_base) < 20 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("reach_bit20", 64'(k < 2000), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", 64'({ser_clk, ser_data, ser_load, apply_busy, apply_done}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NP; i++) model[i] = RST_VAL;
    repeat (300) @(negedge clk);
    check("no_done_after_reset", 64'(done_cnt - dc), 64'd0);
    check("idle_after_reset", 64'(apply_busy), 64'd0);
    for (int i = 0; i < NP; i++) checkOutput_read(AW'(i));

    repeat (5) @(negedge clk);
    check("frames_outstanding", 64'(frame_q.size()), 64'd0);
    check("errs_outstanding", 64'(err_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
